// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared operation encodings and FSM state type for the
//                iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // op[1] selects signed, op[0] selects divide
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Request / result bundle between the EX stage and the
//                multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
    logic             zero;

    modport master (
        output start, op, in1, in2, hi_we, lo_we, hi_wdata, lo_wdata,
        input  busy, done, hi, lo, dz, zero
    );

    modport slave (
        input  start, op, in1, in2, hi_we, lo_we, hi_wdata, lo_wdata,
        output busy, done, hi, lo, dz, zero
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One iteration of the multiply/divide datapath on {acc, q}:
//                a right-shift shift-add step or a left-shift restoring
//                division step, selected by is_div_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic             is_div_i,
    input  wire logic [WIDTH:0]   acc_i,
    input  wire logic [WIDTH-1:0] q_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH:0]   acc_o,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_part;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH+1:0] w_diff;

    // Partial remainder can reach 2*d-1, so the shifted value needs WIDTH+1
    // bits and the trial subtraction one more for the borrow.
    assign w_sum  = acc_i + {1'b0, d_i};
    assign w_part = q_i[0] ? w_sum : acc_i;
    assign w_shl  = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
    assign w_diff = {1'b0, w_shl} - {2'b00, d_i};

    // Select the multiply or divide step result
    always_comb begin
        acc_o = acc_i;
        q_o   = q_i;
        if (is_div_i) begin
            if (!w_diff[WIDTH+1]) begin
                acc_o = w_diff[WIDTH:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = w_shl;
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {1'b0, w_part[WIDTH:1]};
            q_o   = {w_part[0], q_i[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative signed/unsigned multiply and divide (one bit per
//                clock) with architectural HI/LO registers and MTHI/MTLO.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    muldiv_if.slave   mdu_if
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] qr_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dz_q;
    logic             zero_q;

    logic             w_signed, w_div, w_div_zero;
    logic [WIDTH:0]   w_ext1, w_ext2, w_mag1, w_mag2;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0] w_qr_nxt;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_quot, w_rem, w_fix_hi, w_fix_lo;

    // Magnitudes are taken in WIDTH+1 bits so -2^(WIDTH-1) survives intact
    assign w_signed   = mdu_if.op[1];
    assign w_div      = mdu_if.op[0];
    assign w_div_zero = w_div && (mdu_if.in2 == '0);
    assign w_ext1     = {w_signed & mdu_if.in1[WIDTH-1], mdu_if.in1};
    assign w_ext2     = {w_signed & mdu_if.in2[WIDTH-1], mdu_if.in2};
    assign w_mag1     = w_ext1[WIDTH] ? -w_ext1 : w_ext1;
    assign w_mag2     = w_ext2[WIDTH] ? -w_ext2 : w_ext2;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_q[0]),
        .acc_i    (acc_q),
        .q_i      (qr_q),
        .d_i      (a_q),
        .acc_o    (w_acc_nxt),
        .q_o      (w_qr_nxt)
    );

    // Sign fix-up of the unsigned result
    assign w_prod     = {acc_q[WIDTH-1:0], qr_q};
    assign w_prod_fix = neg_res_q ? -w_prod : w_prod;
    assign w_quot     = neg_res_q ? -qr_q : qr_q;
    assign w_rem      = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_fix_hi   = op_q[0] ? w_rem  : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo   = op_q[0] ? w_quot : w_prod_fix[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mdu_if.start) state_d = w_div_zero ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        mdu_if.busy = (state_q == CALC) || (state_q == FIX);
        mdu_if.done = (state_q == DONE);
    end

    // Operand latch, iteration datapath and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            qr_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu_if.start) begin
                        op_q      <= mdu_if.op;
                        acc_q     <= '0;
                        neg_res_q <= w_ext1[WIDTH] ^ w_ext2[WIDTH];
                        neg_rem_q <= w_div & w_ext1[WIDTH];
                        if (w_div) begin
                            qr_q <= w_mag1[WIDTH-1:0];
                            a_q  <= w_mag2[WIDTH-1:0];
                        end else begin
                            qr_q <= w_mag2[WIDTH-1:0];
                            a_q  <= w_mag1[WIDTH-1:0];
                        end
                        if (w_div_zero) begin
                            hi_q   <= '0;
                            lo_q   <= '0;
                            dz_q   <= 1'b1;
                            zero_q <= 1'b1;
                            cnt_q  <= '0;
                        end else begin
                            cnt_q  <= CNT_W'(WIDTH);
                        end
                    end else begin
                        if (mdu_if.hi_we) hi_q <= mdu_if.hi_wdata;
                        if (mdu_if.lo_we) lo_q <= mdu_if.lo_wdata;
                    end
                end
                CALC: begin
                    acc_q <= w_acc_nxt;
                    qr_q  <= w_qr_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    hi_q   <= w_fix_hi;
                    lo_q   <= w_fix_lo;
                    dz_q   <= 1'b0;
                    zero_q <= (w_fix_hi == '0) && (w_fix_lo == '0);
                end
                default: ;
            endcase
        end
    end

    assign mdu_if.hi   = hi_q;
    assign mdu_if.lo   = lo_q;
    assign mdu_if.dz   = dz_q;
    assign mdu_if.zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mdu_if (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          r_done_cyc;
    int          r_busy_cnt;
    logic        r_busy_at_done;
    logic [31:0] r_hi, r_lo, r_lo_c1;
    logic        r_dz, r_zero;

    task automatic clear_inputs();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    // Issue one operation; optionally write LO alongside start and inject a
    // start+hi_we pulse during cycle intf_cyc. Results land in r_*.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic lo_we_s,
                          input logic [31:0] lo_wd, input int intf_cyc);
        @(negedge clk);
        bus.op = op; bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
        bus.lo_we = lo_we_s; bus.lo_wdata = lo_wd;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.lo_we = 1'b0;
        bus.in1 = 32'h5A5A_5A5A; bus.in2 = 32'hA5A5_A5A5;
        r_done_cyc = -1; r_busy_cnt = 0; r_busy_at_done = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (cyc == 1) r_lo_c1 = bus.lo;
            if (bus.done === 1'b1) begin
                r_done_cyc = cyc; r_busy_at_done = bus.busy;
                r_hi = bus.hi; r_lo = bus.lo; r_dz = bus.dz; r_zero = bus.zero;
                break;
            end
            if (bus.busy === 1'b1) r_busy_cnt++;
            if (cyc == intf_cyc) begin
                bus.start = 1'b1; bus.op = OP_DIVU;
                bus.in1 = 32'd100; bus.in2 = 32'd9;
                bus.hi_we = 1'b1; bus.hi_wdata = 32'h1234;
            end else begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.op = OP_MULTU; bus.in1 = '0; bus.in2 = '0;
        bus.hi_wdata = '0; bus.lo_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({bus.busy, bus.done, bus.dz, bus.zero} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.dz, bus.zero}); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, 0);
        n_cmp++; if (r_done_cyc !== 34) begin n_bad++; $display("FAIL multu_done_cycle: got %0d want 34", r_done_cyc); end
        n_cmp++; if (r_busy_cnt !== 33) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 33", r_busy_cnt); end
        n_cmp++; if (r_busy_at_done !== 1'b0) begin n_bad++; $display("FAIL multu_busy_at_done: got %b want 0", r_busy_at_done); end
        n_cmp++; if (r_hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", r_hi); end
        n_cmp++; if (r_lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", r_lo); end
        n_cmp++; if ({r_dz, r_zero} !== 2'b00) begin n_bad++; $display("FAIL multu_dz_zero: got %b want 00", {r_dz, r_zero}); end
    endtask

    task automatic test_signed();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, '0, 0);
        n_cmp++; if (r_hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi: got %h want ffffffff", r_hi); end
        n_cmp++; if (r_lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_neg_lo: got %h want fffffff1", r_lo); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, 0);
        n_cmp++; if (r_done_cyc !== 34) begin n_bad++; $display("FAIL div_done_cycle: got %0d want 34", r_done_cyc); end
        n_cmp++; if (r_lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_quot: got %h want fffffffd", r_lo); end
        n_cmp++; if (r_hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_rem: got %h want ffffffff", r_hi); end
    endtask

    task automatic test_div_zero();
        run_op(OP_DIVU, 32'd10, 32'd0, 1'b0, '0, 0);
        n_cmp++; if (r_done_cyc !== 1) begin n_bad++; $display("FAIL dz_done_cycle: got %0d want 1", r_done_cyc); end
        n_cmp++; if (r_busy_cnt !== 0) begin n_bad++; $display("FAIL dz_busy_cycles: got %0d want 0", r_busy_cnt); end
        n_cmp++; if ({r_hi, r_lo} !== 64'h0) begin n_bad++; $display("FAIL dz_hilo: got %h want 0", {r_hi, r_lo}); end
        n_cmp++; if ({r_dz, r_zero} !== 2'b11) begin n_bad++; $display("FAIL dz_flags: got %b want 11", {r_dz, r_zero}); end
        run_op(OP_DIVU, 32'd10, 32'd3, 1'b0, '0, 0);
        n_cmp++; if (r_lo !== 32'd3) begin n_bad++; $display("FAIL divu_quot: got %h want 00000003", r_lo); end
        n_cmp++; if (r_hi !== 32'd1) begin n_bad++; $display("FAIL divu_rem: got %h want 00000001", r_hi); end
        n_cmp++; if ({r_dz, r_zero} !== 2'b00) begin n_bad++; $display("FAIL divu_flags: got %b want 00", {r_dz, r_zero}); end
        run_op(OP_MULTU, 32'd0, 32'd123, 1'b0, '0, 0);
        n_cmp++; if ({r_dz, r_zero} !== 2'b01) begin n_bad++; $display("FAIL mul_zero_flags: got %b want 01", {r_dz, r_zero}); end
    endtask

    task automatic test_overflow();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, 0);
        n_cmp++; if (r_lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_quot: got %h want 80000000", r_lo); end
        n_cmp++; if (r_hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_rem: got %h want 00000000", r_hi); end
        n_cmp++; if (r_dz !== 1'b0) begin n_bad++; $display("FAIL div_ovf_dz: got %b want 0", r_dz); end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, '0, 0);
        n_cmp++; if (r_hi !== 32'h4000_0000) begin n_bad++; $display("FAIL mult_min_hi: got %h want 40000000", r_hi); end
        n_cmp++; if (r_lo !== 32'h0) begin n_bad++; $display("FAIL mult_min_lo: got %h want 00000000", r_lo); end
    endtask

    task automatic test_busy_ignore();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, '0, 5);
        n_cmp++; if (r_done_cyc !== 34) begin n_bad++; $display("FAIL ign_done_cycle: got %0d want 34", r_done_cyc); end
        n_cmp++; if (r_hi !== 32'h1) begin n_bad++; $display("FAIL ign_hi: got %h want 00000001", r_hi); end
        n_cmp++; if (r_lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL ign_lo: got %h want fffffffe", r_lo); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL ign_no_restart: got %b want 00", {bus.busy, bus.done}); end
        n_cmp++; if (bus.hi !== 32'h1) begin n_bad++; $display("FAIL ign_hi_stable: got %h want 00000001", bus.hi); end
    endtask

    task automatic test_mt_writes();
        @(negedge clk);
        bus.hi_we = 1'b1; bus.hi_wdata = 32'h0000_DEAD;
        @(negedge clk);
        bus.hi_we = 1'b0;
        n_cmp++; if (bus.hi !== 32'h0000_DEAD) begin n_bad++; $display("FAIL mthi: got %h want 0000dead", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mthi_lo_kept: got %h want fffffffe", bus.lo); end
        bus.lo_we = 1'b1; bus.lo_wdata = 32'h0000_1111;
        @(negedge clk);
        bus.lo_we = 1'b0;
        n_cmp++; if (bus.lo !== 32'h0000_1111) begin n_bad++; $display("FAIL mtlo: got %h want 00001111", bus.lo); end
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b1, 32'h0000_5555, 0);
        n_cmp++; if (r_lo_c1 !== 32'h0000_1111) begin n_bad++; $display("FAIL start_lo_we_dropped: got %h want 00001111", r_lo_c1); end
        n_cmp++; if (r_lo !== 32'd42) begin n_bad++; $display("FAIL mul67_lo: got %h want 0000002a", r_lo); end
        n_cmp++; if (r_hi !== 32'd0) begin n_bad++; $display("FAIL mul67_hi: got %h want 00000000", r_hi); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        bus.op = OP_DIV; bus.in1 = 32'd100; bus.in2 = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_flags: got %b want 00", {bus.busy, bus.done}); end
        n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin n_bad++; $display("FAIL mid_rst_hilo: got %h want 0", {bus.hi, bus.lo}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL mid_rst_no_done: got %0d want 0", done_seen); end
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, '0, 0);
        n_cmp++; if (r_done_cyc !== 34) begin n_bad++; $display("FAIL post_rst_done_cycle: got %0d want 34", r_done_cyc); end
        n_cmp++; if (r_lo !== 32'd42) begin n_bad++; $display("FAIL post_rst_lo: got %h want 0000002a", r_lo); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_mt_writes();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
